// File: rtl/nasti_ram_arbiter.sv
// Two-requester to one-slave NASTI arbiter. Read and write paths are granted
// independently, round-robin per burst, with combinational forwarding.
//
// Channel payload layouts (MSB first):
//   AR/AW : {id, addr, len[7:0], size[2:0], burst[1:0], lock, cache[3:0],
//            prot[2:0], qos[3:0], region[3:0], user}
//   W     : {data, strb, last, user}
//   R     : {id, data, resp[1:0], last, user}
//   B     : {id, resp[1:0], user}
module nasti_ram_arbiter #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1,
    localparam int AX_WIDTH  = ID_WIDTH + ADDR_WIDTH + 29 + USER_WIDTH,
    localparam int W_WIDTH   = DATA_WIDTH + DATA_WIDTH / 8 + 1 + USER_WIDTH,
    localparam int R_WIDTH   = ID_WIDTH + DATA_WIDTH + 3 + USER_WIDTH,
    localparam int B_WIDTH   = ID_WIDTH + 2 + USER_WIDTH
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                i_s0_ar_valid,
    output logic                o_s0_ar_ready,
    input  logic [AX_WIDTH-1:0] i_s0_ar_bits,
    input  logic                i_s0_aw_valid,
    output logic                o_s0_aw_ready,
    input  logic [AX_WIDTH-1:0] i_s0_aw_bits,
    input  logic                i_s0_w_valid,
    output logic                o_s0_w_ready,
    input  logic [W_WIDTH-1:0]  i_s0_w_bits,
    output logic                o_s0_r_valid,
    input  logic                i_s0_r_ready,
    output logic [R_WIDTH-1:0]  o_s0_r_bits,
    output logic                o_s0_b_valid,
    input  logic                i_s0_b_ready,
    output logic [B_WIDTH-1:0]  o_s0_b_bits,

    input  logic                i_s1_ar_valid,
    output logic                o_s1_ar_ready,
    input  logic [AX_WIDTH-1:0] i_s1_ar_bits,
    input  logic                i_s1_aw_valid,
    output logic                o_s1_aw_ready,
    input  logic [AX_WIDTH-1:0] i_s1_aw_bits,
    input  logic                i_s1_w_valid,
    output logic                o_s1_w_ready,
    input  logic [W_WIDTH-1:0]  i_s1_w_bits,
    output logic                o_s1_r_valid,
    input  logic                i_s1_r_ready,
    output logic [R_WIDTH-1:0]  o_s1_r_bits,
    output logic                o_s1_b_valid,
    input  logic                i_s1_b_ready,
    output logic [B_WIDTH-1:0]  o_s1_b_bits,

    output logic                o_m_ar_valid,
    input  logic                i_m_ar_ready,
    output logic [AX_WIDTH-1:0] o_m_ar_bits,
    output logic                o_m_aw_valid,
    input  logic                i_m_aw_ready,
    output logic [AX_WIDTH-1:0] o_m_aw_bits,
    output logic                o_m_w_valid,
    input  logic                i_m_w_ready,
    output logic [W_WIDTH-1:0]  o_m_w_bits,
    input  logic                i_m_r_valid,
    output logic                o_m_r_ready,
    input  logic [R_WIDTH-1:0]  i_m_r_bits,
    input  logic                i_m_b_valid,
    output logic                o_m_b_ready,
    input  logic [B_WIDTH-1:0]  i_m_b_bits
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

    rd_state_t r_rd_state;
    logic      r_rd_own;
    logic      r_rd_rr;
    wr_state_t r_wr_state;
    logic      r_wr_own;
    logic      r_wr_rr;

    logic w_rd_cand;
    logic w_rd_sel;
    logic w_ar_phase;
    logic w_r_phase;
    logic w_ar_fire;
    logic w_r_done;

    logic w_wr_cand;
    logic w_wr_sel;
    logic w_aw_phase;
    logic w_w_phase;
    logic w_b_phase;
    logic w_aw_fire;
    logic w_w_done;
    logic w_b_done;

    // Read path: the grant is decided in IDLE and locked in the owner register afterwards.
    assign w_rd_cand  = (i_s0_ar_valid && i_s1_ar_valid) ? r_rd_rr : i_s1_ar_valid;
    assign w_rd_sel   = (r_rd_state == R_IDLE) ? w_rd_cand : r_rd_own;
    assign w_ar_phase = rstn && ((r_rd_state == R_IDLE) || (r_rd_state == R_ADDR));
    assign w_r_phase  = rstn && (r_rd_state == R_DATA);

    assign o_m_ar_valid  = w_ar_phase && (w_rd_sel ? i_s1_ar_valid : i_s0_ar_valid);
    assign o_m_ar_bits   = w_ar_phase ? (w_rd_sel ? i_s1_ar_bits : i_s0_ar_bits) : '0;
    assign o_s0_ar_ready = w_ar_phase && !w_rd_sel && i_m_ar_ready;
    assign o_s1_ar_ready = w_ar_phase &&  w_rd_sel && i_m_ar_ready;

    assign o_m_r_ready  = w_r_phase && (r_rd_own ? i_s1_r_ready : i_s0_r_ready);
    assign o_s0_r_valid = w_r_phase && !r_rd_own && i_m_r_valid;
    assign o_s1_r_valid = w_r_phase &&  r_rd_own && i_m_r_valid;
    assign o_s0_r_bits  = (w_r_phase && !r_rd_own) ? i_m_r_bits : '0;
    assign o_s1_r_bits  = (w_r_phase &&  r_rd_own) ? i_m_r_bits : '0;

    assign w_ar_fire = o_m_ar_valid && i_m_ar_ready;
    assign w_r_done  = i_m_r_valid && o_m_r_ready && i_m_r_bits[USER_WIDTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_state <= R_IDLE;
            r_rd_own   <= 1'b0;
            r_rd_rr    <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (o_m_ar_valid) begin
                        r_rd_own   <= w_rd_sel;
                        r_rd_state <= i_m_ar_ready ? R_DATA : R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (w_ar_fire) begin
                        r_rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_done) begin
                        r_rd_state <= R_IDLE;
                        r_rd_rr    <= ~r_rd_own;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    // Write path: W is only forwarded once the AW handshake has happened.
    assign w_wr_cand  = (i_s0_aw_valid && i_s1_aw_valid) ? r_wr_rr : i_s1_aw_valid;
    assign w_wr_sel   = (r_wr_state == W_IDLE) ? w_wr_cand : r_wr_own;
    assign w_aw_phase = rstn && ((r_wr_state == W_IDLE) || (r_wr_state == W_ADDR));
    assign w_w_phase  = rstn && (r_wr_state == W_DATA);
    assign w_b_phase  = rstn && (r_wr_state == W_RESP);

    assign o_m_aw_valid  = w_aw_phase && (w_wr_sel ? i_s1_aw_valid : i_s0_aw_valid);
    assign o_m_aw_bits   = w_aw_phase ? (w_wr_sel ? i_s1_aw_bits : i_s0_aw_bits) : '0;
    assign o_s0_aw_ready = w_aw_phase && !w_wr_sel && i_m_aw_ready;
    assign o_s1_aw_ready = w_aw_phase &&  w_wr_sel && i_m_aw_ready;

    assign o_m_w_valid  = w_w_phase && (r_wr_own ? i_s1_w_valid : i_s0_w_valid);
    assign o_m_w_bits   = w_w_phase ? (r_wr_own ? i_s1_w_bits : i_s0_w_bits) : '0;
    assign o_s0_w_ready = w_w_phase && !r_wr_own && i_m_w_ready;
    assign o_s1_w_ready = w_w_phase &&  r_wr_own && i_m_w_ready;

    assign o_m_b_ready  = w_b_phase && (r_wr_own ? i_s1_b_ready : i_s0_b_ready);
    assign o_s0_b_valid = w_b_phase && !r_wr_own && i_m_b_valid;
    assign o_s1_b_valid = w_b_phase &&  r_wr_own && i_m_b_valid;
    assign o_s0_b_bits  = (w_b_phase && !r_wr_own) ? i_m_b_bits : '0;
    assign o_s1_b_bits  = (w_b_phase &&  r_wr_own) ? i_m_b_bits : '0;

    assign w_aw_fire = o_m_aw_valid && i_m_aw_ready;
    assign w_w_done  = o_m_w_valid && i_m_w_ready && o_m_w_bits[USER_WIDTH];
    assign w_b_done  = i_m_b_valid && o_m_b_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_state <= W_IDLE;
            r_wr_own   <= 1'b0;
            r_wr_rr    <= 1'b0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (o_m_aw_valid) begin
                        r_wr_own   <= w_wr_sel;
                        r_wr_state <= i_m_aw_ready ? W_DATA : W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (w_aw_fire) begin
                        r_wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_done) begin
                        r_wr_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (w_b_done) begin
                        r_wr_state <= W_IDLE;
                        r_wr_rr    <= ~r_wr_own;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nasti_ram_arbiter.sv
// Self-checking bench for nasti_ram_arbiter: directed and randomised bursts on
// both paths, checked against a round-robin reference model of the grants.
module tb_nasti_ram_arbiter;

    localparam int ID_W   = 1;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 128;
    localparam int USER_W = 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int AX_W   = ID_W + ADDR_W + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + USER_W;
    localparam int W_W    = DATA_W + STRB_W + 1 + USER_W;
    localparam int R_W    = ID_W + DATA_W + 2 + 1 + USER_W;
    localparam int B_W    = ID_W + 2 + USER_W;

    logic clk = 1'b0;
    logic rstn;

    logic [1:0]      sArValid, sAwValid, sWValid, sRReady, sBReady;
    logic [AX_W-1:0] sArBits [2];
    logic [AX_W-1:0] sAwBits [2];
    logic [W_W-1:0]  sWBits [2];
    wire  [1:0]      sArReady, sAwReady, sWReady, sRValid, sBValid;
    wire  [R_W-1:0]  sRBits [2];
    wire  [B_W-1:0]  sBBits [2];

    logic            mArReady, mAwReady, mWReady, mRValid, mBValid;
    logic [R_W-1:0]  mRBits;
    logic [B_W-1:0]  mBBits;
    wire             mArValid, mAwValid, mWValid, mRReady, mBReady;
    wire  [AX_W-1:0] mArBits, mAwBits;
    wire  [W_W-1:0]  mWBits;

    int   checks;
    int   errors;
    logic rdFavored;
    logic wrFavored;
    int   rc, wc;

    always #5 clk = ~clk;

    nasti_ram_arbiter dut (
        .clk(clk), .rstn(rstn),
        .i_s0_ar_valid(sArValid[0]), .o_s0_ar_ready(sArReady[0]), .i_s0_ar_bits(sArBits[0]),
        .i_s0_aw_valid(sAwValid[0]), .o_s0_aw_ready(sAwReady[0]), .i_s0_aw_bits(sAwBits[0]),
        .i_s0_w_valid(sWValid[0]),   .o_s0_w_ready(sWReady[0]),   .i_s0_w_bits(sWBits[0]),
        .o_s0_r_valid(sRValid[0]),   .i_s0_r_ready(sRReady[0]),   .o_s0_r_bits(sRBits[0]),
        .o_s0_b_valid(sBValid[0]),   .i_s0_b_ready(sBReady[0]),   .o_s0_b_bits(sBBits[0]),
        .i_s1_ar_valid(sArValid[1]), .o_s1_ar_ready(sArReady[1]), .i_s1_ar_bits(sArBits[1]),
        .i_s1_aw_valid(sAwValid[1]), .o_s1_aw_ready(sAwReady[1]), .i_s1_aw_bits(sAwBits[1]),
        .i_s1_w_valid(sWValid[1]),   .o_s1_w_ready(sWReady[1]),   .i_s1_w_bits(sWBits[1]),
        .o_s1_r_valid(sRValid[1]),   .i_s1_r_ready(sRReady[1]),   .o_s1_r_bits(sRBits[1]),
        .o_s1_b_valid(sBValid[1]),   .i_s1_b_ready(sBReady[1]),   .o_s1_b_bits(sBBits[1]),
        .o_m_ar_valid(mArValid), .i_m_ar_ready(mArReady), .o_m_ar_bits(mArBits),
        .o_m_aw_valid(mAwValid), .i_m_aw_ready(mAwReady), .o_m_aw_bits(mAwBits),
        .o_m_w_valid(mWValid),   .i_m_w_ready(mWReady),   .o_m_w_bits(mWBits),
        .i_m_r_valid(mRValid),   .o_m_r_ready(mRReady),   .i_m_r_bits(mRBits),
        .i_m_b_valid(mBValid),   .o_m_b_ready(mBReady),   .i_m_b_bits(mBBits)
    );

    function automatic logic [DATA_W-1:0] rndData();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [AX_W-1:0] mkAx(input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        return {ID_W'($urandom), addr, len, 3'd4, 2'b01, 1'b0, 4'($urandom), 3'($urandom),
                4'($urandom), 4'($urandom), USER_W'($urandom)};
    endfunction

    function automatic logic [R_W-1:0] mkR(input logic last);
        return {ID_W'($urandom), rndData(), 2'($urandom), last, USER_W'($urandom)};
    endfunction

    function automatic logic [W_W-1:0] mkW(input logic last);
        return {rndData(), STRB_W'($urandom), last, USER_W'($urandom)};
    endfunction

    function automatic logic anyOutput();
        return |{mArValid, mArBits, mAwValid, mAwBits, mWValid, mWBits, mRReady, mBReady,
                 sArReady, sAwReady, sWReady, sRValid, sRBits[0], sRBits[1],
                 sBValid, sBBits[0], sBBits[1]};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every bench-owned input to its idle value.
    task automatic applyStimulus();
        sArValid = '0; sAwValid = '0; sWValid = '0; sRReady = '0; sBReady = '0;
        for (int i = 0; i < 2; i++) begin
            sArBits[i] = '0; sAwBits[i] = '0; sWBits[i] = '0;
        end
        mArReady = 1'b0; mAwReady = 1'b0; mWReady = 1'b0; mRValid = 1'b0; mBValid = 1'b0;
        mRBits = '0; mBBits = '0;
    endtask

    // One read burst. Winner follows the round-robin model over 'mask';
    // 'lateMask' requesters join at address cycle 'joinAt' and must lose.
    task automatic readRound(input logic [1:0] mask, input logic [1:0] lateMask, input int joinAt,
                             input int len, input int arDelay, input bit stall, output int cycles);
        logic win, lose;
        logic [AX_W-1:0] req [2];
        logic [R_W-1:0] rb;
        int beat, n;
        win  = (mask == 2'b11) ? rdFavored : mask[1];
        lose = ~win;
        req[0] = mkAx(ADDR_W'($urandom), 8'(len));
        req[1] = mkAx(ADDR_W'($urandom), 8'(len));
        sArBits[0] = req[0];
        sArBits[1] = req[1];
        sArValid = mask;
        cycles = 0;
        for (int d = 0; d <= arDelay; d++) begin
            if (d == joinAt) sArValid = sArValid | lateMask;
            mArReady = (d == arDelay);
            #1;
            checkOutput("ar_valid", 256'(mArValid), 256'(1));
            checkOutput("ar_bits", 256'(mArBits), 256'(req[win]));
            checkOutput("ar_ready_win", 256'(sArReady[win]), 256'(mArReady));
            checkOutput("ar_ready_lose", 256'(sArReady[lose]), 256'(0));
            tick();
            cycles++;
        end
        mArReady = 1'b0;
        sArValid = (mask | lateMask) & (win ? 2'b01 : 2'b10);
        beat = 0;
        n = 0;
        while (beat <= len && n < 500) begin
            mRValid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            sRReady[win]  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            sRReady[lose] = 1'b1;
            rb = mkR(beat == len);
            mRBits = rb;
            #1;
            checkOutput("r_valid_win", 256'(sRValid[win]), 256'(mRValid));
            checkOutput("r_bits_win", 256'(sRBits[win]), 256'(rb));
            checkOutput("r_valid_lose", 256'(sRValid[lose]), 256'(0));
            checkOutput("r_ready_m", 256'(mRReady), 256'(sRReady[win]));
            checkOutput("ar_held_in_data", 256'(mArValid), 256'(0));
            checkOutput("ar_ready_lose_data", 256'(sArReady[lose]), 256'(0));
            if (mRValid && sRReady[win]) beat++;
            tick();
            cycles++;
            n++;
        end
        checkOutput("r_beats_done", 256'(beat), 256'(len + 1));
        mRValid = 1'b0;
        sRReady = '0;
        sArValid = '0;
        rdFavored = ~win;
    endtask

    // One write burst: AW grant, W beats (never before AW), then B.
    task automatic writeRound(input logic [1:0] mask, input int len, input int awDelay,
                              input bit stall, output int cycles);
        logic win, lose;
        logic [AX_W-1:0] req [2];
        logic [W_W-1:0] wb;
        logic [B_W-1:0] bb;
        int beat, n;
        bit done;
        win  = (mask == 2'b11) ? wrFavored : mask[1];
        lose = ~win;
        req[0] = mkAx(ADDR_W'($urandom), 8'(len));
        req[1] = mkAx(ADDR_W'($urandom), 8'(len));
        sAwBits[0] = req[0];
        sAwBits[1] = req[1];
        sAwValid = mask;
        sWValid  = 2'b11;
        sWBits[0] = mkW(1'b0);
        sWBits[1] = mkW(1'b0);
        mWReady = 1'b1;
        cycles = 0;
        for (int d = 0; d <= awDelay; d++) begin
            mAwReady = (d == awDelay);
            #1;
            checkOutput("aw_valid", 256'(mAwValid), 256'(1));
            checkOutput("aw_bits", 256'(mAwBits), 256'(req[win]));
            checkOutput("aw_ready_win", 256'(sAwReady[win]), 256'(mAwReady));
            checkOutput("aw_ready_lose", 256'(sAwReady[lose]), 256'(0));
            checkOutput("w_before_aw", 256'(mWValid), 256'(0));
            checkOutput("w_ready_before_aw", 256'(sWReady), 256'(0));
            tick();
            cycles++;
        end
        mAwReady = 1'b0;
        sAwValid = mask & (win ? 2'b01 : 2'b10);
        beat = 0;
        n = 0;
        while (beat <= len && n < 500) begin
            sWValid[win]  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            sWValid[lose] = 1'b1;
            wb = mkW(beat == len);
            sWBits[win]  = wb;
            sWBits[lose] = mkW(1'b1);
            mWReady = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            checkOutput("w_valid_m", 256'(mWValid), 256'(sWValid[win]));
            checkOutput("w_bits_m", 256'(mWBits), 256'(wb));
            checkOutput("w_ready_win", 256'(sWReady[win]), 256'(mWReady));
            checkOutput("w_ready_lose", 256'(sWReady[lose]), 256'(0));
            checkOutput("aw_held_in_data", 256'(mAwValid), 256'(0));
            if (sWValid[win] && mWReady) beat++;
            tick();
            cycles++;
            n++;
        end
        checkOutput("w_beats_done", 256'(beat), 256'(len + 1));
        sWValid = '0;
        mWReady = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done && n < 500) begin
            mBValid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            sBReady[win]  = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            sBReady[lose] = 1'b1;
            bb = {ID_W'($urandom), 2'($urandom), USER_W'($urandom)};
            mBBits = bb;
            #1;
            checkOutput("b_valid_win", 256'(sBValid[win]), 256'(mBValid));
            checkOutput("b_bits_win", 256'(sBBits[win]), 256'(bb));
            checkOutput("b_valid_lose", 256'(sBValid[lose]), 256'(0));
            checkOutput("b_ready_m", 256'(mBReady), 256'(sBReady[win]));
            if (mBValid && sBReady[win]) done = 1'b1;
            tick();
            cycles++;
            n++;
        end
        checkOutput("b_done", 256'(done), 256'(1));
        mBValid = 1'b0;
        sBReady = '0;
        sAwValid = '0;
        wrFavored = ~win;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rdFavored = 1'b0;
        wrFavored = 1'b0;

        // Reset with every input busy: all outputs must stay zero.
        applyStimulus();
        rstn = 1'b0;
        sArValid = 2'b11; sAwValid = 2'b11; sWValid = 2'b11; sRReady = 2'b11; sBReady = 2'b11;
        sArBits[0] = mkAx(16'h1234, 8'd3); sArBits[1] = mkAx(16'h4321, 8'd3);
        sAwBits[0] = mkAx(16'h5555, 8'd1); sAwBits[1] = mkAx(16'haaaa, 8'd1);
        sWBits[0] = mkW(1'b1); sWBits[1] = mkW(1'b1);
        mArReady = 1'b1; mAwReady = 1'b1; mWReady = 1'b1; mRValid = 1'b1; mBValid = 1'b1;
        mRBits = mkR(1'b1); mBBits = 4'hf;
        #2;
        checkOutput("reset_outputs_zero", 256'(anyOutput()), 256'(0));
        repeat (2) tick();
        checkOutput("reset_outputs_zero_held", 256'(anyOutput()), 256'(0));
        applyStimulus();
        rstn = 1'b1;
        tick();

        // Single read by s0, len=3.
        readRound(2'b01, 2'b00, -1, 3, 0, 1'b0, rc);
        // Three simultaneous single-beat rounds.
        repeat (3) readRound(2'b11, 2'b00, -1, 0, 0, 1'b0, rc);
        // AR held off 5 cycles, s1 joins on cycle 2 and must wait.
        readRound(2'b01, 2'b10, 2, 1, 5, 1'b0, rc);
        // Write by s1, len=1, then a contested write.
        writeRound(2'b10, 1, 1, 1'b0, wc);
        writeRound(2'b11, 0, 0, 1'b0, wc);

        // Concurrent read and write, len=7 each, neither may stall the other.
        fork
            readRound(2'b01, 2'b00, -1, 7, 0, 1'b0, rc);
            writeRound(2'b10, 7, 0, 1'b0, wc);
        join
        checkOutput("concurrent_rd_cycles", 256'(rc), 256'(9));
        checkOutput("concurrent_wr_cycles", 256'(wc), 256'(10));

        // Randomised rounds with stalls on both sides.
        for (int k = 0; k < 12; k++) begin
            logic [1:0] msk;
            msk = 2'($urandom_range(1, 3));
            readRound(msk, (msk == 2'b11) ? 2'b00 : ~msk, $urandom_range(1, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, rc);
            writeRound(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1, wc);
        end
        for (int k = 0; k < 4; k++) begin
            fork
                readRound(2'($urandom_range(1, 3)), 2'b00, -1, $urandom_range(0, 4),
                          $urandom_range(0, 2), 1'b1, rc);
                writeRound(2'($urandom_range(1, 3)), $urandom_range(0, 4), $urandom_range(0, 2), 1'b1, wc);
            join
        end

        // Reset in the middle of a 4-beat read by s0.
        sArValid = 2'b01;
        sArBits[0] = mkAx(16'h0040, 8'd3);
        mArReady = 1'b1;
        tick();
        sArValid = 2'b00;
        mArReady = 1'b0;
        sRReady = 2'b11;
        for (int b = 0; b < 2; b++) begin
            mRValid = 1'b1;
            mRBits = mkR(1'b0);
            #1;
            checkOutput("pre_reset_r_valid", 256'(sRValid[0]), 256'(1));
            tick();
        end
        mRBits = mkR(1'b0);
        sArValid = 2'b10;
        sArBits[1] = mkAx(16'h0200, 8'd0);
        mArReady = 1'b1;
        rstn = 1'b0;
        #1;
        checkOutput("mid_burst_reset_zero", 256'(anyOutput()), 256'(0));
        checkOutput("mid_burst_reset_r_valid", 256'(sRValid[0]), 256'(0));
        tick();
        checkOutput("mid_burst_reset_zero_held", 256'(anyOutput()), 256'(0));
        applyStimulus();
        rstn = 1'b1;
        rdFavored = 1'b0;
        wrFavored = 1'b0;
        readRound(2'b10, 2'b00, -1, 1, 0, 1'b0, rc);
        readRound(2'b11, 2'b00, -1, 0, 0, 1'b0, rc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
